// File: rtl/mem_access_stage_pkg.sv
// mem_access_stage_pkg
//   Shared types for the MIPS memory stage: FSM state encoding, the default
//   bus timeout, and the MEM/WB payload struct carried to writeback.
package mem_access_stage_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } stateT;

  localparam int TIMEOUT_DEFAULT = 16;

  typedef struct packed {
    logic        regWrite;
    logic        memToReg;
    logic [31:0] readData;
    logic [31:0] aluResult;
    logic [4:0]  writeReg;
  } memWbT;

endpackage

// File: rtl/mem_access_stage_wb.sv
// mem_wb_reg
//   MEM/WB pipeline register. Captures every cycle. A bubble zeroes the
//   control bits so writeback does nothing. Read data only updates on a
//   completed load and otherwise holds.
// Ports:
//   Clk, Rst_n      clock, async active-low reset
//   bubble          squash RegWrite/MemToReg for this capture
//   loadEn          capture readDataIn (load completed this cycle)
//   regWriteIn..    instruction fields from the MEM stage
//   wb              registered MEM/WB payload
module mem_wb_reg
  import mem_access_stage_pkg::*;
(
  input  logic        Clk,
  input  logic        Rst_n,
  input  logic        bubble,
  input  logic        loadEn,
  input  logic        regWriteIn,
  input  logic        memToRegIn,
  input  logic [31:0] aluResultIn,
  input  logic [4:0]  writeRegIn,
  input  logic [31:0] readDataIn,
  output memWbT       wb
);

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      wb <= '0;
    end else begin
      wb.regWrite  <= regWriteIn & ~bubble;
      wb.memToReg  <= memToRegIn & ~bubble;
      wb.aluResult <= aluResultIn;
      wb.writeReg  <= writeRegIn;
      if (loadEn) wb.readData <= readDataIn;
    end
  end

endmodule

// File: rtl/mem_access_stage.sv
// mem_access_stage
//   MEM stage of the 5-stage MIPS pipeline. Turns the EX/MEM load/store into
//   a ready/ack data-memory request, stalls the front of the pipe while the
//   access is outstanding, abandons it after TIMEOUT_CYCLES request cycles,
//   and owns the MEM/WB register.
// Ports:
//   Clk, Rst_n                 clock, async active-low reset
//   *M inputs                  EX/MEM control and data
//   DmemReq/We/Addr/WData      request side of the memory bus
//   DmemRData/DmemAck          response side of the memory bus
//   StallM                     freeze PC, IF/ID, ID/EX, EX/MEM
//   *W outputs                 MEM/WB register
//   AlignErr, BusErr           one-cycle error pulses
module mem_access_stage
  import mem_access_stage_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = TIMEOUT_DEFAULT,
  parameter int CNT_W          = 8
) (
  input  logic        Clk,
  input  logic        Rst_n,
  input  logic        MemReadM,
  input  logic        MemWriteM,
  input  logic        MemToRegM,
  input  logic        RegWriteM,
  input  logic [31:0] ALUresultM,
  input  logic [31:0] ReadData2M,
  input  logic [4:0]  WriteRegM,
  output logic        DmemReq,
  output logic        DmemWe,
  output logic [31:0] DmemAddr,
  output logic [31:0] DmemWData,
  input  logic [31:0] DmemRData,
  input  logic        DmemAck,
  output logic        StallM,
  output logic        RegWriteW,
  output logic        MemToRegW,
  output logic [31:0] ReadDataW,
  output logic [31:0] ALUresultW,
  output logic [4:0]  WriteRegW,
  output logic        AlignErr,
  output logic        BusErr
);

  stateT            state;
  logic [CNT_W-1:0] cnt;
  logic             dropped;

  logic  access, aligned, reqBase, ackV, timeout, bubble, loadEn;
  memWbT wb;

  assign access  = MemReadM | MemWriteM;
  assign aligned = (ALUresultM[1:0] == 2'b00);

  // Request the instruction would make if not timing out this cycle. Gated
  // by Rst_n so the request is withdrawn the moment reset asserts.
  assign reqBase = Rst_n & access & aligned & ~dropped;
  // An ack only counts against a live request; ack beats timeout.
  assign ackV    = reqBase & DmemAck;
  assign timeout = (state == WAIT) & ~DmemAck & (cnt == CNT_W'(TIMEOUT_CYCLES));

  assign DmemReq   = reqBase & ~timeout;
  assign DmemWe    = MemWriteM;
  assign DmemAddr  = ALUresultM;
  assign DmemWData = ReadData2M;
  assign StallM    = reqBase & ~DmemAck & ~timeout;

  // Any access that did not complete this cycle (stall, timeout, misaligned,
  // dropped) leaves a bubble in MEM/WB. Store writes the read path only if
  // it is also a load, and write wins, so loadEn excludes stores.
  assign bubble = access & ~ackV;
  assign loadEn = ackV & MemReadM & ~MemWriteM;

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      dropped  <= 1'b0;
      AlignErr <= 1'b0;
      BusErr   <= 1'b0;
    end else begin
      AlignErr <= access & ~aligned;
      BusErr   <= timeout;
      // dropped suppresses a re-request of the abandoned access; it clears
      // on the first unstalled cycle, when EX/MEM has moved on.
      if (timeout)      dropped <= 1'b1;
      else if (!StallM) dropped <= 1'b0;
      case (state)
        IDLE: begin
          if (reqBase && !DmemAck) begin
            state <= WAIT;
            cnt   <= CNT_W'(1);
          end
        end
        WAIT: begin
          if (DmemAck || timeout) begin
            state <= IDLE;
            cnt   <= '0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  mem_wb_reg uMemWb (
    .Clk         (Clk),
    .Rst_n       (Rst_n),
    .bubble      (bubble),
    .loadEn      (loadEn),
    .regWriteIn  (RegWriteM),
    .memToRegIn  (MemToRegM),
    .aluResultIn (ALUresultM),
    .writeRegIn  (WriteRegM),
    .readDataIn  (DmemRData),
    .wb          (wb)
  );

  assign RegWriteW  = wb.regWrite;
  assign MemToRegW  = wb.memToReg;
  assign ReadDataW  = wb.readData;
  assign ALUresultW = wb.aluResult;
  assign WriteRegW  = wb.writeReg;

endmodule

// File: tb/tb_mem_access_stage.sv
module tb_mem_access_stage;

  logic        Clk = 1'b0;
  logic        Rst_n;
  logic        MemReadM, MemWriteM, MemToRegM, RegWriteM;
  logic [31:0] ALUresultM, ReadData2M;
  logic [4:0]  WriteRegM;
  logic        DmemReq, DmemWe;
  logic [31:0] DmemAddr, DmemWData, DmemRData;
  logic        DmemAck, StallM;
  logic        RegWriteW, MemToRegW;
  logic [31:0] ReadDataW, ALUresultW;
  logic [4:0]  WriteRegW;
  logic        AlignErr, BusErr;

  int errors = 0;
  int checks = 0;

  always #5 Clk = ~Clk;

  mem_access_stage #(.TIMEOUT_CYCLES(4), .CNT_W(8)) dut (
    .Clk(Clk), .Rst_n(Rst_n),
    .MemReadM(MemReadM), .MemWriteM(MemWriteM), .MemToRegM(MemToRegM),
    .RegWriteM(RegWriteM), .ALUresultM(ALUresultM), .ReadData2M(ReadData2M),
    .WriteRegM(WriteRegM),
    .DmemReq(DmemReq), .DmemWe(DmemWe), .DmemAddr(DmemAddr),
    .DmemWData(DmemWData), .DmemRData(DmemRData), .DmemAck(DmemAck),
    .StallM(StallM),
    .RegWriteW(RegWriteW), .MemToRegW(MemToRegW), .ReadDataW(ReadDataW),
    .ALUresultW(ALUresultW), .WriteRegW(WriteRegW),
    .AlignErr(AlignErr), .BusErr(BusErr)
  );

  task automatic setInstr(input logic rd, input logic wr, input logic m2r,
                          input logic rw, input logic [31:0] addr,
                          input logic [31:0] data, input logic [4:0] wreg);
    MemReadM = rd; MemWriteM = wr; MemToRegM = m2r; RegWriteM = rw;
    ALUresultM = addr; ReadData2M = data; WriteRegM = wreg;
  endtask

  task automatic stepEdge();
    @(posedge Clk); #1;
  endtask

  task automatic test_reset();
    setInstr(0, 0, 0, 1, 32'h77, 0, 5'd5); DmemAck = 0;
    stepEdge();
    setInstr(1, 0, 1, 1, 32'h40, 0, 5'd6);
    stepEdge();                                  // now waiting on the load
    @(negedge Clk);
    checks++; if (DmemReq !== 1'b1) begin errors++; $display("FAIL rst_pre_req got=%b exp=1", DmemReq); end
    Rst_n = 0; #1;
    checks++; if (DmemReq !== 1'b0 || StallM !== 1'b0) begin errors++; $display("FAIL rst_async_comb req=%b stall=%b exp=0/0", DmemReq, StallM); end
    checks++; if (ALUresultW !== 32'h0 || WriteRegW !== 5'd0) begin errors++; $display("FAIL rst_async_w alu=%h wreg=%0d exp=0/0", ALUresultW, WriteRegW); end
    repeat (2) @(posedge Clk); #1;
    checks++;
    if ({RegWriteW, MemToRegW, ReadDataW, ALUresultW, WriteRegW, AlignErr, BusErr, DmemReq, StallM} !== '0) begin
      errors++; $display("FAIL rst_hold_all rw=%b m2r=%b rd=%h alu=%h wr=%0d ae=%b be=%b req=%b st=%b exp=all0",
        RegWriteW, MemToRegW, ReadDataW, ALUresultW, WriteRegW, AlignErr, BusErr, DmemReq, StallM);
    end
    Rst_n = 1;
    setInstr(0, 0, 0, 1, 32'h55, 0, 5'd7);
    @(negedge Clk);
    checks++; if (StallM !== 1'b0 || DmemReq !== 1'b0) begin errors++; $display("FAIL rst_rel_comb stall=%b req=%b exp=0/0", StallM, DmemReq); end
    stepEdge();
    checks++;
    if (RegWriteW !== 1'b1 || MemToRegW !== 1'b0 || ALUresultW !== 32'h55 || WriteRegW !== 5'd7) begin
      errors++; $display("FAIL rst_rel_wb rw=%b m2r=%b alu=%h wr=%0d exp=1/0/55/7", RegWriteW, MemToRegW, ALUresultW, WriteRegW);
    end
  endtask

  task automatic test_zero_wait_load();
    setInstr(1, 0, 1, 1, 32'h100, 0, 5'd3); DmemAck = 1; DmemRData = 32'hDEADBEEF;
    @(negedge Clk);
    checks++;
    if (DmemReq !== 1'b1 || DmemWe !== 1'b0 || StallM !== 1'b0 || DmemAddr !== 32'h100) begin
      errors++; $display("FAIL zw_bus req=%b we=%b stall=%b addr=%h exp=1/0/0/100", DmemReq, DmemWe, StallM, DmemAddr);
    end
    stepEdge();
    checks++;
    if (ReadDataW !== 32'hDEADBEEF || RegWriteW !== 1'b1 || MemToRegW !== 1'b1 || WriteRegW !== 5'd3) begin
      errors++; $display("FAIL zw_wb rd=%h rw=%b m2r=%b wr=%0d exp=deadbeef/1/1/3", ReadDataW, RegWriteW, MemToRegW, WriteRegW);
    end
    setInstr(0, 0, 0, 0, 0, 0, 0); DmemAck = 0; DmemRData = 32'h0;
  endtask

  task automatic test_wait_store();
    int reqCnt = 0, stallCnt = 0;
    setInstr(0, 1, 0, 0, 32'h204, 32'h12345678, 5'd0); DmemAck = 0;
    for (int i = 0; i < 4; i++) begin
      DmemAck = (i == 3);
      @(negedge Clk);
      if (DmemReq === 1'b1 && DmemWe === 1'b1 && DmemWData === 32'h12345678) reqCnt++;
      if (StallM === 1'b1) stallCnt++;
      checks++; if (StallM !== (i < 3)) begin errors++; $display("FAIL st_stall_%0d got=%b exp=%b", i, StallM, (i < 3)); end
      stepEdge();
      checks++; if (RegWriteW !== 1'b0) begin errors++; $display("FAIL st_rw_%0d got=%b exp=0", i, RegWriteW); end
    end
    checks++; if (reqCnt != 4) begin errors++; $display("FAIL st_req_cycles got=%0d exp=4", reqCnt); end
    checks++; if (stallCnt != 3) begin errors++; $display("FAIL st_stall_cycles got=%0d exp=3", stallCnt); end
    checks++; if (ReadDataW !== 32'hDEADBEEF) begin errors++; $display("FAIL st_rdata_hold got=%h exp=deadbeef", ReadDataW); end
    setInstr(0, 0, 0, 0, 0, 0, 0); DmemAck = 0;
    @(negedge Clk);
    checks++; if (DmemReq !== 1'b0 || StallM !== 1'b0) begin errors++; $display("FAIL st_after req=%b stall=%b exp=0/0", DmemReq, StallM); end
    stepEdge();
  endtask

  task automatic test_misaligned();
    setInstr(1, 0, 1, 1, 32'h102, 0, 5'd4); DmemAck = 0;
    @(negedge Clk);
    checks++; if (DmemReq !== 1'b0 || StallM !== 1'b0) begin errors++; $display("FAIL mis_comb req=%b stall=%b exp=0/0", DmemReq, StallM); end
    stepEdge();
    checks++; if (AlignErr !== 1'b1 || RegWriteW !== 1'b0) begin errors++; $display("FAIL mis_pulse ae=%b rw=%b exp=1/0", AlignErr, RegWriteW); end
    checks++; if (ReadDataW !== 32'hDEADBEEF) begin errors++; $display("FAIL mis_rdata got=%h exp=deadbeef", ReadDataW); end
    setInstr(0, 0, 0, 0, 0, 0, 0);
    stepEdge();
    checks++; if (AlignErr !== 1'b0) begin errors++; $display("FAIL mis_one_cycle got=%b exp=0", AlignErr); end
  endtask

  task automatic test_timeout();
    setInstr(1, 0, 1, 1, 32'h300, 0, 5'd9); DmemAck = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge Clk);
      checks++;
      if (StallM !== (i < 4) || DmemReq !== (i < 4)) begin
        errors++; $display("FAIL to_comb_%0d stall=%b req=%b exp=%b/%b", i, StallM, DmemReq, (i < 4), (i < 4));
      end
      stepEdge();
      checks++;
      if (BusErr !== (i == 4) || RegWriteW !== 1'b0) begin
        errors++; $display("FAIL to_reg_%0d be=%b rw=%b exp=%b/0", i, BusErr, RegWriteW, (i == 4));
      end
    end
    // same instruction still presented: must not be re-requested
    @(negedge Clk);
    checks++; if (DmemReq !== 1'b0 || StallM !== 1'b0) begin errors++; $display("FAIL to_norereq req=%b stall=%b exp=0/0", DmemReq, StallM); end
    stepEdge();
    checks++; if (BusErr !== 1'b0 || RegWriteW !== 1'b0) begin errors++; $display("FAIL to_after be=%b rw=%b exp=0/0", BusErr, RegWriteW); end
    setInstr(1, 0, 1, 1, 32'h304, 0, 5'd10); DmemAck = 1; DmemRData = 32'hCAFEF00D;
    @(negedge Clk);
    checks++; if (DmemReq !== 1'b1 || StallM !== 1'b0) begin errors++; $display("FAIL to_next_comb req=%b stall=%b exp=1/0", DmemReq, StallM); end
    stepEdge();
    checks++;
    if (ReadDataW !== 32'hCAFEF00D || RegWriteW !== 1'b1 || WriteRegW !== 5'd10) begin
      errors++; $display("FAIL to_next_wb rd=%h rw=%b wr=%0d exp=cafef00d/1/10", ReadDataW, RegWriteW, WriteRegW);
    end
    setInstr(0, 0, 0, 0, 0, 0, 0); DmemAck = 0;
  endtask

  task automatic test_ack_tie();
    setInstr(1, 0, 1, 1, 32'h400, 0, 5'd11); DmemAck = 0; DmemRData = 32'h0BADF00D;
    for (int i = 0; i < 5; i++) begin
      DmemAck = (i == 4);
      @(negedge Clk);
      checks++;
      if (DmemReq !== 1'b1 || StallM !== (i < 4)) begin
        errors++; $display("FAIL tie_comb_%0d req=%b stall=%b exp=1/%b", i, DmemReq, StallM, (i < 4));
      end
      stepEdge();
    end
    checks++;
    if (ReadDataW !== 32'h0BADF00D || RegWriteW !== 1'b1 || BusErr !== 1'b0) begin
      errors++; $display("FAIL tie_wb rd=%h rw=%b be=%b exp=0badf00d/1/0", ReadDataW, RegWriteW, BusErr);
    end
    setInstr(0, 0, 0, 0, 0, 0, 0); DmemAck = 0;
    stepEdge();
    checks++; if (BusErr !== 1'b0) begin errors++; $display("FAIL tie_nobuserr got=%b exp=0", BusErr); end
  endtask

  task automatic test_reset_in_wait();
    setInstr(1, 0, 1, 1, 32'h500, 0, 5'd12); DmemAck = 0;
    stepEdge();
    stepEdge();
    @(negedge Clk);
    checks++; if (DmemReq !== 1'b1 || StallM !== 1'b1) begin errors++; $display("FAIL rw_pre req=%b stall=%b exp=1/1", DmemReq, StallM); end
    #2 Rst_n = 0; #1;
    checks++; if (DmemReq !== 1'b0 || StallM !== 1'b0) begin errors++; $display("FAIL rw_drop req=%b stall=%b exp=0/0", DmemReq, StallM); end
    stepEdge();
    Rst_n = 1;
    // a fresh zero-wait load must complete normally after reset
    setInstr(1, 0, 1, 1, 32'h504, 0, 5'd13); DmemAck = 1; DmemRData = 32'h600DCAFE;
    stepEdge();
    checks++;
    if (ReadDataW !== 32'h600DCAFE || RegWriteW !== 1'b1 || WriteRegW !== 5'd13) begin
      errors++; $display("FAIL rw_recover rd=%h rw=%b wr=%0d exp=600dcafe/1/13", ReadDataW, RegWriteW, WriteRegW);
    end
    setInstr(0, 0, 0, 0, 0, 0, 0); DmemAck = 0;
  endtask

  initial begin
    Rst_n = 0;
    setInstr(0, 0, 0, 0, 0, 0, 0); DmemAck = 0; DmemRData = 0;
    repeat (2) @(posedge Clk);
    #1 Rst_n = 1;
    test_reset();
    test_zero_wait_load();
    test_wait_store();
    test_misaligned();
    test_timeout();
    test_ack_tie();
    test_reset_in_wait();
    repeat (2) @(posedge Clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
